// File: rtl/neuron_mac_writeback.sv
// neuron_mac_writeback: per-neuron signed MAC, rescale, saturate, optional ReLU, one write per neuron
module neuron_mac_writeback #(
  parameter int DATA_W  = 8,
  parameter int FRAC_W  = 4,
  parameter int ACC_W   = 24,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              term_valid,
  input  logic              neuron_last,
  input  logic              layer_last,
  input  logic [ADDR_W-1:0] term_waddr,
  input  logic              relu_en,
  input  logic [DATA_W-1:0] weight_data,
  input  logic [DATA_W-1:0] neuro_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              layer_done,
  output logic              sat_flag
);
  localparam int PW = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [MEM_LAT-1:0] dl_valid, dl_last, dl_llast;
  logic [ADDR_W-1:0] dl_waddr [MEM_LAT];
  logic relu_q;
  logic signed [PW-1:0] prod_n;
  logic signed [ACC_W-1:0] acc, prod, sum, s;
  logic ov_hi, ov_lo;
  logic [DATA_W-1:0] sat_w, res;
  logic out_v, out_last, out_llast;
  logic [ADDR_W-1:0] out_addr;
  // product of the words aligned with the delay-line output, accumulated, rescaled, clamped, ReLU'd
  always_comb begin
    out_v = dl_valid[MEM_LAT-1];
    out_last = dl_last[MEM_LAT-1];
    out_llast = dl_llast[MEM_LAT-1];
    out_addr = dl_waddr[MEM_LAT-1];
    prod_n = PW'($signed(weight_data)) * PW'($signed(neuro_data));
    prod = ACC_W'(prod_n);
    sum = acc + prod;
    s = sum >>> FRAC_W;
    ov_hi = s > S_MAX;
    ov_lo = s < S_MIN;
    sat_w = ov_hi ? S_MAX[DATA_W-1:0] : ov_lo ? S_MIN[DATA_W-1:0] : s[DATA_W-1:0];
    res = (relu_q && sat_w[DATA_W-1]) ? '0 : sat_w;
    busy = state != IDLE;
  end
  // term tags travel MEM_LAT stages so they meet the RAM words; start drops every in-flight term
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_valid <= '0;
      dl_last <= '0;
      dl_llast <= '0;
      for (int i = 0; i < MEM_LAT; i++) dl_waddr[i] <= '0;
    end else begin
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_last[i] <= dl_last[i-1];
        dl_llast[i] <= dl_llast[i-1];
        dl_waddr[i] <= dl_waddr[i-1];
      end
      dl_valid[0] <= term_valid && state == RUN && !start;
      dl_last[0] <= neuron_last || layer_last;
      dl_llast[0] <= layer_last;
      dl_waddr[0] <= term_waddr;
      if (start) dl_valid <= '0;
    end
  end
  // layer FSM, accumulator and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      relu_q <= 1'b0;
      sat_flag <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      layer_done <= 1'b0;
    end else if (start) begin
      state <= RUN;
      acc <= '0;
      relu_q <= relu_en;
      sat_flag <= 1'b0;
      wr_en <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      wr_en <= out_v && out_last;
      layer_done <= out_v && out_last && out_llast;
      if (out_v) acc <= out_last ? '0 : sum;
      if (out_v && out_last) begin
        wr_addr <= out_addr;
        wr_data <= res;
        if (ov_hi || ov_lo) sat_flag <= 1'b1;
      end
      if (state == RUN && term_valid && layer_last) state <= DRAIN;
      else if (state == DRAIN && layer_done) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_neuron_mac_writeback.sv
// tb_neuron_mac_writeback: random and directed layers checked against a cycle-timeline reference model
module tb_neuron_mac_writeback;
  localparam int DW = 8, FW = 4, AW = 24, ADW = 8, ML = 1;
  localparam int MAXC = 8192;
  logic clk, reset, start, term_valid, neuron_last, layer_last, relu_en;
  logic [ADW-1:0] term_waddr, wr_addr;
  logic [DW-1:0] weight_data, neuro_data, wr_data;
  logic wr_en, busy, layer_done, sat_flag;

  neuron_mac_writeback #(.DATA_W(DW), .FRAC_W(FW), .ACC_W(AW), .ADDR_W(ADW), .MEM_LAT(ML)) dut (
    .clk(clk), .reset(reset), .start(start), .term_valid(term_valid), .neuron_last(neuron_last),
    .layer_last(layer_last), .term_waddr(term_waddr), .relu_en(relu_en), .weight_data(weight_data),
    .neuro_data(neuro_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .layer_done(layer_done), .sat_flag(sat_flag));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0, n_cmp = 0, n_bad = 0, n_wr = 0;
  logic chk_on = 1'b0;
  logic [DW-1:0] w_at [MAXC];
  logic [DW-1:0] x_at [MAXC];
  logic e_we [MAXC], e_done [MAXC], e_busy [MAXC], e_sat [MAXC];
  logic [ADW-1:0] e_addr [MAXC];
  logic [DW-1:0] e_data [MAXC];
  int h_cyc [1024];
  logic [ADW-1:0] h_addr [1024];
  logic [DW-1:0] h_data [1024];
  logic h_done [1024];
  logic m_run = 1'b0, m_relu = 1'b0;
  longint m_sum = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // exact result: wrap to ACC_W, floor-divide by 2^FRAC_W, clamp to DATA_W, then ReLU
  function automatic logic [DW-1:0] model(input longint sum, input logic relu, output logic clamped);
    logic signed [AW-1:0] wv;
    longint v, q, d;
    wv = sum[AW-1:0];
    v = longint'(wv);
    d = longint'(2 ** FW);
    q = (v >= 0) ? v / d : -((-v + d - 1) / d);
    clamped = (q > 127) || (q < -128);
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    if (relu && q < 0) q = 0;
    return q[DW-1:0];
  endfunction

  task automatic drive(input logic st, input logic rl, input logic tv, input logic nl, input logic ll,
                       input logic [ADW-1:0] a, input logic signed [DW-1:0] w, input logic signed [DW-1:0] x,
                       input logic rs);
    int n, wc;
    logic cl;
    n = cyc;
    start = st; relu_en = rl; term_valid = tv; neuron_last = nl; layer_last = ll; term_waddr = a; reset = rs;
    w_at[n+ML] = w;
    x_at[n+ML] = x;
    if (rs) begin
      m_run = 0; m_sum = 0; m_relu = 0;
      for (int c = n + 1; c < MAXC; c++) begin e_we[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_sat[c] = 0; end
    end else if (st) begin
      m_run = 1; m_sum = 0; m_relu = rl;
      for (int c = n + 1; c < MAXC; c++) begin e_we[c] = 0; e_done[c] = 0; e_busy[c] = 1; e_sat[c] = 0; end
    end else if (tv && m_run) begin
      m_sum += longint'(w) * longint'(x);
      if (nl || ll) begin
        wc = n + ML + 1;
        e_we[wc] = 1; e_addr[wc] = a; e_data[wc] = model(m_sum, m_relu, cl); e_done[wc] = ll;
        if (cl) for (int c = wc; c < MAXC; c++) e_sat[c] = 1;
        m_sum = 0;
        if (ll) begin
          m_run = 0;
          for (int c = wc + 1; c < MAXC; c++) e_busy[c] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    weight_data = w_at[cyc];
    neuro_data = x_at[cyc];
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom), 0);
  endtask
  task automatic strt(input logic rl);
    drive(1, rl, 0, 0, 0, 0, 8'($urandom), 8'($urandom), 0);
  endtask
  task automatic term(input int w, input int x, input logic nl, input logic ll, input logic [ADW-1:0] a);
    drive(0, 0, 1, nl, ll, a, 8'(w), 8'(x), 0);
  endtask

  function automatic int rnd_w();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 40)) - 20;
  endfunction

  // every cycle: outputs against the model timeline
  always @(negedge clk) if (chk_on) begin
    chk("wr_en", {31'b0, wr_en}, {31'b0, e_we[cyc]});
    if (e_we[cyc]) begin
      chk("wr_addr", {24'b0, wr_addr}, {24'b0, e_addr[cyc]});
      chk("wr_data", {24'b0, wr_data}, {24'b0, e_data[cyc]});
    end
    chk("layer_done", {31'b0, layer_done}, {31'b0, e_done[cyc]});
    chk("busy", {31'b0, busy}, {31'b0, e_busy[cyc]});
    chk("sat_flag", {31'b0, sat_flag}, {31'b0, e_sat[cyc]});
    if (wr_en === 1'b1 && n_wr < 1024) begin
      h_cyc[n_wr] = cyc; h_addr[n_wr] = wr_addr; h_data[n_wr] = wr_data; h_done[n_wr] = layer_done;
      n_wr++;
    end
  end

  initial begin
    int t0, w0, nn, k;
    for (int c = 0; c < MAXC; c++) begin
      w_at[c] = 8'($urandom); x_at[c] = 8'($urandom);
      e_we[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_sat[c] = 0; e_addr[c] = 0; e_data[c] = 0;
    end
    start = 0; relu_en = 0; term_valid = 0; neuron_last = 0; layer_last = 0; term_waddr = 0;
    weight_data = 0; neuro_data = 0; reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk_on = 1'b1;
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_wr_en", {31'b0, wr_en}, 0);
    chk("rst_wr_data", {24'b0, wr_data}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    idle();
    // one neuron, three terms
    strt(0); t0 = cyc; w0 = n_wr;
    term(16, 16, 0, 0, 'h40); term(32, 16, 0, 0, 'h40); term(-16, 16, 0, 1, 'h40);
    repeat (4) idle();
    chk("t1_count", n_wr - w0, 1);
    chk("t1_cycle", h_cyc[w0], t0 + 4);
    chk("t1_addr", {24'b0, h_addr[w0]}, 'h40);
    chk("t1_data", {24'b0, h_data[w0]}, 32);
    chk("t1_done", {31'b0, h_done[w0]}, 1);
    // positive and negative saturation
    strt(0); w0 = n_wr;
    repeat (3) term(127, 127, 0, 0, 'h41);
    term(127, 127, 0, 1, 'h41);
    repeat (3) idle();
    chk("t2_pos_data", {24'b0, h_data[w0]}, 127);
    chk("t2_pos_sat", {31'b0, sat_flag}, 1);
    strt(0);
    chk("t2_sat_clear", {31'b0, sat_flag}, 0);
    w0 = n_wr;
    repeat (3) term(-128, 127, 0, 0, 'h41);
    term(-128, 127, 0, 1, 'h41);
    repeat (3) idle();
    chk("t2_neg_data", {24'b0, h_data[w0]}, 'h80);
    chk("t2_neg_sat", {31'b0, sat_flag}, 1);
    // ReLU and truncation toward -inf
    strt(1); w0 = n_wr; term(-16, 16, 0, 1, 'h42); repeat (3) idle();
    chk("t3_relu", {24'b0, h_data[w0]}, 0);
    strt(0); w0 = n_wr; term(-16, 16, 0, 1, 'h42); repeat (3) idle();
    chk("t3_neg", {24'b0, h_data[w0]}, 'hF0);
    strt(0); w0 = n_wr; term(-1, 1, 0, 1, 'h42); repeat (3) idle();
    chk("t3_floor", {24'b0, h_data[w0]}, 'hFF);
    // back-to-back neurons
    strt(0); w0 = n_wr;
    term(16, 16, 0, 0, 'h10); term(16, 16, 1, 0, 'h10); term(16, 16, 0, 0, 'h11); term(16, 16, 0, 1, 'h11);
    repeat (4) idle();
    chk("t4_count", n_wr - w0, 2);
    chk("t4_a0", {24'b0, h_addr[w0]}, 'h10);
    chk("t4_d0", {24'b0, h_data[w0]}, 32);
    chk("t4_done0", {31'b0, h_done[w0]}, 0);
    chk("t4_a1", {24'b0, h_addr[w0+1]}, 'h11);
    chk("t4_d1", {24'b0, h_data[w0+1]}, 32);
    chk("t4_gap", h_cyc[w0+1] - h_cyc[w0], 2);
    chk("t4_done1", {31'b0, h_done[w0+1]}, 1);
    // restart mid-neuron with a colliding term
    strt(0);
    term(16, 16, 0, 0, 'h20); term(16, 16, 0, 0, 'h20);
    w0 = n_wr;
    drive(1, 0, 1, 1, 0, 'h21, 16, 16, 0);
    term(16, 16, 0, 1, 'h22);
    repeat (4) idle();
    chk("t5_count", n_wr - w0, 1);
    chk("t5_addr", {24'b0, h_addr[w0]}, 'h22);
    chk("t5_data", {24'b0, h_data[w0]}, 16);
    // reset one cycle before a pending write
    strt(0);
    term(127, 127, 0, 1, 'h33);
    w0 = n_wr;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t6_wr_en", {31'b0, wr_en}, 0);
    chk("t6_wr_addr", {24'b0, wr_addr}, 0);
    chk("t6_wr_data", {24'b0, wr_data}, 0);
    chk("t6_busy", {31'b0, busy}, 0);
    chk("t6_sat", {31'b0, sat_flag}, 0);
    repeat (3) idle();
    chk("t6_count", n_wr - w0, 0);
    // random layers with gaps, ignored strobes and occasional restarts
    for (int l = 0; l < 30; l++) begin
      strt(1'($urandom));
      nn = $urandom_range(1, 4);
      for (int j = 0; j < nn; j++) begin
        k = $urandom_range(1, 5);
        for (int i = 0; i < k; i++) begin
          while ($urandom_range(0, 3) == 0)
            drive(0, 0, 0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
          if (i > 0 && $urandom_range(0, 30) == 0)
            drive(1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 8'($urandom), 8'(rnd_w()), 8'(rnd_w()), 0);
          term(rnd_w(), rnd_w(), i == k - 1, i == k - 1 && j == nn - 1, 8'($urandom));
        end
      end
      repeat ($urandom_range(1, 5))
        drive(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
    end
    repeat (4) idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
